// File: rtl/pc_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// pc_redirect_ctrl
//
// Purpose:
//   Resolves branches and jumps in the ID stage. When a taken instruction is
//   accepted, the block issues a one-cycle redirect pulse with the registered
//   target, then holds flush high for FLUSH_CYCLES consecutive cycles so the
//   wrong-path instructions fetched behind it are squashed. It also counts
//   taken redirects with a saturating counter.
//
//   The flush window includes the redirect cycle. The instruction presented
//   on the last flush cycle is the first correct-path instruction and is
//   evaluated normally, so back-to-back redirects are FLUSH_CYCLES apart.
//
// Parameters:
//   WIDTH        datapath / PC width
//   FLUSH_CYCLES flush window length in cycles (1..7)
//   CNT_W        redirect counter width
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   valid_in       IF/ID instruction fields are valid
//   stall          ID stage held; instruction not evaluated
//   op             000 none, 001 BEQZ, 010 BNEZ, 011 BLTZ, 100 BGEZ,
//                  101 J, 110 JR, 111 reserved
//   rs             forwarded source register value
//   pc_plus2       PC+2 of the instruction in IF/ID
//   imm_ext        sign-extended displacement
//   redirect_valid one-cycle pulse: load redirect_pc into the PC
//   redirect_pc    registered jump target (held between redirects)
//   flush          squash younger wrong-path instructions
//   busy           FSM is in FLUSH
//   redirect_count saturating count of redirects taken
// -----------------------------------------------------------------------------
module pc_redirect_ctrl #(
    parameter int WIDTH        = 16,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic             stall,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] pc_plus2,
    input  logic [WIDTH-1:0] imm_ext,
    output logic             redirect_valid,
    output logic [WIDTH-1:0] redirect_pc,
    output logic             flush,
    output logic             busy,
    output logic [CNT_W-1:0] redirect_count
);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [2:0] OP_BEQZ = 3'b001;
    localparam logic [2:0] OP_BNEZ = 3'b010;
    localparam logic [2:0] OP_BLTZ = 3'b011;
    localparam logic [2:0] OP_BGEZ = 3'b100;
    localparam logic [2:0] OP_J    = 3'b101;
    localparam logic [2:0] OP_JR   = 3'b110;

    // Counter is loaded with FLUSH_CYCLES-1 on the redirect edge, because the
    // redirect cycle itself is the first cycle of the flush window.
    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

    state_t           state_reg, state_next;
    logic [2:0]       fcnt_reg, fcnt_next;
    logic             redirect_valid_reg, redirect_valid_next;
    logic [WIDTH-1:0] redirect_pc_reg, redirect_pc_next;
    logic             flush_reg, flush_next;
    logic             busy_reg, busy_next;
    logic [CNT_W-1:0] count_reg, count_next;

    logic             taken;
    logic             accept;
    logic             take;
    logic [WIDTH-1:0] target;

    // Branch condition evaluation
    always_comb begin
        taken = 1'b0;
        case (op)
            OP_BEQZ: taken = (rs == '0);
            OP_BNEZ: taken = (rs != '0);
            OP_BLTZ: taken = rs[WIDTH-1];
            OP_BGEZ: taken = ~rs[WIDTH-1];
            OP_J,
            OP_JR:   taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    // Target wraps modulo 2^WIDTH; the carry is simply dropped.
    assign target = (op == OP_JR) ? (rs + imm_ext) : (pc_plus2 + imm_ext);

    // Evaluation is allowed in IDLE, and on the final flush cycle (the return
    // edge), which is what gives exact FLUSH_CYCLES spacing between redirects.
    assign accept = valid_in && !stall &&
                    ((state_reg == IDLE) || (fcnt_reg == 3'd0));
    assign take   = accept && taken;

    // Next-state and registered-output logic
    always_comb begin
        state_next          = state_reg;
        fcnt_next           = fcnt_reg;
        redirect_valid_next = 1'b0;
        redirect_pc_next    = redirect_pc_reg;
        count_next          = count_reg;

        case (state_reg)
            IDLE: begin
                if (take) begin
                    state_next = FLUSH;
                    fcnt_next  = FLUSH_INIT;
                end
            end
            FLUSH: begin
                // Stall is deliberately not consulted here: the window never
                // pauses or stretches.
                if (fcnt_reg == 3'd0) begin
                    if (take) begin
                        state_next = FLUSH;
                        fcnt_next  = FLUSH_INIT;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    fcnt_next = fcnt_reg - 3'd1;
                end
            end
            default: begin
                state_next = IDLE;
                fcnt_next  = 3'd0;
            end
        endcase

        if (take) begin
            redirect_valid_next = 1'b1;
            redirect_pc_next    = target;
            if (count_reg != '1)
                count_next = count_reg + CNT_W'(1);
        end

        flush_next = (state_next == FLUSH);
        busy_next  = (state_next == FLUSH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg          <= IDLE;
            fcnt_reg           <= 3'd0;
            redirect_valid_reg <= 1'b0;
            redirect_pc_reg    <= '0;
            flush_reg          <= 1'b0;
            busy_reg           <= 1'b0;
            count_reg          <= '0;
        end else begin
            state_reg          <= state_next;
            fcnt_reg           <= fcnt_next;
            redirect_valid_reg <= redirect_valid_next;
            redirect_pc_reg    <= redirect_pc_next;
            flush_reg          <= flush_next;
            busy_reg           <= busy_next;
            count_reg          <= count_next;
        end
    end

    assign redirect_valid = redirect_valid_reg;
    assign redirect_pc    = redirect_pc_reg;
    assign flush          = flush_reg;
    assign busy           = busy_reg;
    assign redirect_count = count_reg;

endmodule

// File: doc/pc_redirect_ctrl.md
PC_REDIRECT_CTRL -- requirements
Module: pc_redirect_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: datapath and PC width.
REQ-002 The block SHALL have parameter FLUSH_CYCLES, default 2, legal range 1..7: number of consecutive flush cycles per redirect.
REQ-003 The block SHALL have parameter CNT_W, default 16: width of the redirect counter.
REQ-004 The block SHALL have port clk, input, 1 bit: rising-edge clock, the only clock.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port valid_in, input, 1 bit: the IF/ID instruction fields are valid this cycle.
REQ-007 The block SHALL have port stall, input, 1 bit: the ID stage is held; the instruction is not evaluated.
REQ-008 The block SHALL have port op, input, 3 bits: 000 none, 001 BEQZ, 010 BNEZ, 011 BLTZ, 100 BGEZ, 101 J, 110 JR, 111 reserved.
REQ-009 The block SHALL have port rs, input, WIDTH bits: forwarded source register value.
REQ-010 The block SHALL have port pc_plus2, input, WIDTH bits: PC+2 of the instruction in IF/ID.
REQ-011 The block SHALL have port imm_ext, input, WIDTH bits: sign-extended displacement.
REQ-012 The block SHALL have port redirect_valid, output, 1 bit: one-cycle pulse; redirect_pc is to be loaded into the PC.
REQ-013 The block SHALL have port redirect_pc, output, WIDTH bits: registered jump target.
REQ-014 The block SHALL have port flush, output, 1 bit: squash the younger wrong-path instructions.
REQ-015 The block SHALL have port busy, output, 1 bit: the FSM is in FLUSH.
REQ-016 The block SHALL have port redirect_count, output, CNT_W bits: number of redirects taken.

Function
REQ-017 An instruction SHALL be accepted only when valid_in=1, stall=0 and the FSM is in IDLE.
REQ-018 Taken conditions SHALL be: BEQZ rs==0; BNEZ rs!=0; BLTZ rs[WIDTH-1]==1; BGEZ rs[WIDTH-1]==0; J and JR always; op 000 and 111 never.
REQ-019 The target SHALL be pc_plus2+imm_ext for branches and J, and rs+imm_ext for JR, computed modulo 2^WIDTH with the carry discarded.
REQ-020 An accepted taken instruction SHALL cause, in the next cycle, redirect_valid=1 for exactly one cycle, redirect_pc=target, and flush=1.
REQ-021 The FSM SHALL have two states, IDLE and FLUSH; IDLE SHALL go to FLUSH on an accepted taken instruction, otherwise it SHALL stay in IDLE.
REQ-022 In FLUSH, flush SHALL stay asserted for exactly FLUSH_CYCLES consecutive cycles, counted by a down-counter, and the FSM SHALL then return to IDLE.
REQ-023 In FLUSH, valid_in SHALL be ignored (wrong-path instructions) and no new redirect SHALL be issued.
REQ-024 stall SHALL NOT extend or pause the flush window; flush takes priority over stall.
REQ-025 On the cycle the FSM returns to IDLE, a valid, unstalled instruction SHALL be accepted normally, so back-to-back redirects are separated by exactly FLUSH_CYCLES cycles.
REQ-026 Not-taken, stalled or non-valid instructions SHALL leave all outputs unchanged, except that redirect_valid SHALL be 0.
REQ-027 redirect_pc SHALL hold its last value between redirects.
REQ-028 redirect_count SHALL increment by 1 on each redirect_valid pulse and saturate at all-ones.
REQ-029 All outputs SHALL be registered; the block SHALL have no combinational path from any input to any output.

Reset
REQ-030 Assertion of rst_n=0 SHALL immediately and asynchronously force state IDLE, redirect_valid=0, redirect_pc=0, flush=0, busy=0, redirect_count=0 and the flush counter to 0, including in the middle of a flush window.
REQ-031 After rst_n is released, the first rising clock edge SHALL be able to accept an instruction.

Verification
REQ-032 The bench SHALL cover BEQZ with rs=0, pc_plus2=0x0010, imm_ext=0x0006: the next cycle gives redirect_valid=1 and redirect_pc=0x0016, then flush=1 for 2 cycles and redirect_count=1.
REQ-033 The bench SHALL cover BNEZ with rs=0: no redirect and no flush, with redirect_pc unchanged.
REQ-034 The bench SHALL cover JR with rs=0xFFFE and imm_ext=0x0004: redirect_pc=0x0002 (wrap-around).
REQ-035 The bench SHALL cover J issued, then valid J presented during the flush window with stall toggling: exactly one redirect, flush for exactly FLUSH_CYCLES cycles, and the second J accepted only after the return to IDLE.
REQ-036 The bench SHALL cover BLTZ with rs=0x8000 and stall=1: no action; then stall=0 gives a redirect.
REQ-037 The bench SHALL cover rst_n pulsed low mid-flush: flush, busy and redirect_count go to 0 immediately, and with CNT_W=2 the counter saturates at 3 after 5 redirects.
